// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared constants for the instruction-fetch prefetch queue.
//               Holds the default parameter values, the field widths of one
//               queue entry {address, instruction} and small sizing helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Default parameter values
    localparam int IFQ_ADDR_W   = 12;
    localparam int IFQ_INST_W   = 8;
    localparam int IFQ_DEPTH    = 4;
    localparam int IFQ_RESET_PC = 0;

    // Queue-entry field widths for the default configuration.
    // An entry is packed as {address, instruction}; the address sits on top.
    localparam int ENTRY_ADDR_W = IFQ_ADDR_W;
    localparam int ENTRY_INST_W = IFQ_INST_W;
    localparam int ENTRY_W      = ENTRY_ADDR_W + ENTRY_INST_W;

    // Width of one packed queue entry for an arbitrary configuration
    function automatic int entry_w(input int addr_w, input int inst_w);
        return addr_w + inst_w;
    endfunction

    // Width of an occupancy counter able to hold 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_pq_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pq_if
// Description : Bundle of the fetch-unit control, memory-request and
//               instruction-delivery signals.
//   ifetch_en  : permits new fetch requests
//   branch     : redirect pulse, tgt_addr is the new fetch address
//   mem_req/mem_addr/mem_gnt/mem_rdata : one-cycle-latency memory port
//   inst_valid/inst_ready/inst_o/inst_addr/next_addr : queue head
// Modports    : master - the fetch unit, slave - its environment
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_pq_if #(
    parameter int ADDR_W = ifetch_pkg::IFQ_ADDR_W,
    parameter int INST_W = ifetch_pkg::IFQ_INST_W
) ();
    import ifetch_pkg::*;

    logic              ifetch_en;
    logic              branch;
    logic [ADDR_W-1:0] tgt_addr;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [INST_W-1:0] mem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr;
    logic [ADDR_W-1:0] next_addr;

    modport master (
        input  ifetch_en, branch, tgt_addr, mem_gnt, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_o, inst_addr, next_addr
    );

    modport slave (
        output ifetch_en, branch, tgt_addr, mem_gnt, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_o, inst_addr, next_addr
    );

endinterface
`default_nettype wire

// File: rtl/ifetch_q.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_q
// Description : Parametrised synchronous FIFO with push, pop, flush and an
//               occupancy count. Head data is read combinationally.
//   clk, reset_ : clock, asynchronous active-low reset
//   push_i/data_i : write one entry
//   pop_i       : retire the head entry
//   flush_i     : drop every entry (wins over push/pop)
//   data_o      : head entry, count_o : number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_q #(
    parameter int WIDTH = ifetch_pkg::ENTRY_W,
    parameter int DEPTH = ifetch_pkg::IFQ_DEPTH
) (
    input  wire logic                                 clk,
    input  wire logic                                 reset_,
    input  wire logic                                 push_i,
    input  wire logic                                 pop_i,
    input  wire logic                                 flush_i,
    input  wire logic [WIDTH-1:0]                     data_i,
    output logic      [WIDTH-1:0]                     data_o,
    output logic      [ifetch_pkg::cnt_w(DEPTH)-1:0]  count_o
);
    import ifetch_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Guard against pop-on-empty and push-on-full so the pointers can never
    // drift apart from the count even if the caller misbehaves.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read once count covers it
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_pq.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pq
// Description : Instruction prefetch unit. Issues sequential fetch requests
//               to a one-cycle-latency memory, captures each response with
//               its address in a prefetch queue and presents the queue head
//               to the consumer. A branch flushes the queue, drops the
//               response in flight and redirects the fetch PC.
//   clk    : rising-edge clock
//   reset_ : asynchronous active-low reset
//   bus    : ifetch_pq_if.master (control, memory port, queue head)
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_pq #(
    parameter int ADDR_W   = ifetch_pkg::IFQ_ADDR_W,
    parameter int INST_W   = ifetch_pkg::IFQ_INST_W,
    parameter int DEPTH    = ifetch_pkg::IFQ_DEPTH,
    parameter int RESET_PC = ifetch_pkg::IFQ_RESET_PC
) (
    input  wire logic    clk,
    input  wire logic    reset_,
    ifetch_pq_if.master  bus
);
    import ifetch_pkg::*;

    localparam int ENT_W = entry_w(ADDR_W, INST_W);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] fpc_q,      fpc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              inflight_q, inflight_d;

    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic [ENT_W-1:0]  push_data;
    logic [OCC_W-1:0]  occ;
    logic              valid;
    logic              pop;
    logic              push;
    logic              req;
    logic              accept;
    logic [ADDR_W-1:0] head_addr;
    logic [INST_W-1:0] head_inst;

    assign valid = (count != '0);
    assign pop   = valid && bus.inst_ready;

    // Occupancy seen by the request decision: stored entries minus the one
    // leaving this cycle, plus the slot reserved by the response in flight.
    // Reserving the slot at acceptance guarantees every response has room.
    always_comb begin
        occ = OCC_W'(count) - OCC_W'(pop) + OCC_W'(inflight_q);
        req = reset_ && bus.ifetch_en && !bus.branch && (occ < OCC_W'(DEPTH));
    end

    assign accept = req && bus.mem_gnt;

    // A response landing in a branch cycle belongs to the abandoned path
    assign push      = inflight_q && !bus.branch;
    assign push_data = {req_addr_q, bus.mem_rdata};

    always_comb begin
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        inflight_d = 1'b0;
        if (bus.branch) begin
            fpc_d = bus.tgt_addr;
        end else if (accept) begin
            fpc_d      = fpc_q + ADDR_W'(1);
            req_addr_d = fpc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fpc_q      <= ADDR_W'(RESET_PC);
            req_addr_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
        end
    end

    ifetch_q #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_q (
        .clk     (clk),
        .reset_  (reset_),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.branch),
        .data_i  (push_data),
        .data_o  (head),
        .count_o (count)
    );

    // Head fields read as zero while the queue is empty, which also gives
    // the required zero outputs straight out of reset.
    assign head_addr = valid ? head[ENT_W-1:INST_W] : '0;
    assign head_inst = valid ? head[INST_W-1:0]     : '0;

    assign bus.mem_req    = req;
    assign bus.mem_addr   = fpc_q;
    assign bus.inst_valid = valid;
    assign bus.inst_addr  = head_addr;
    assign bus.inst_o     = head_inst;
    assign bus.next_addr  = head_addr + ADDR_W'(1);

endmodule
`default_nettype wire

// File: tb/tb_ifetch_pq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_pq
// Description : Self-checking bench for ifetch_pq. A one-cycle memory model
//               answers requests; a scoreboard queue holds every accepted
//               fetch and is compared against the queue head on delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_pq;
    import ifetch_pkg::*;

    localparam int AW    = 12;
    localparam int IW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_;

    ifetch_pq_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

    ifetch_pq #(
        .ADDR_W   (AW),
        .INST_W   (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
    } ent_t;

    typedef struct {
        bit            en;
        bit            gnt;
        bit            rdy;
        bit            e_req;
        logic [AW-1:0] e_addr;
        bit            e_valid;
        logic [AW-1:0] e_iaddr;
    } vec_t;

    ent_t          sb[$];
    int            n_vec = 0;
    int            n_bad = 0;
    logic [AW-1:0] m_pc;
    bit            m_infl;
    bit            acc_prev;
    logic [AW-1:0] acc_addr;
    vec_t          tbl[6];

    function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ a[11:4] ^ 8'h5A;
    endfunction

    function automatic vec_t mkv(input bit en, input bit gnt, input bit rdy,
                                 input bit e_req, input logic [AW-1:0] e_addr,
                                 input bit e_valid, input logic [AW-1:0] e_iaddr);
        vec_t v;
        v.en = en; v.gnt = gnt; v.rdy = rdy; v.e_req = e_req;
        v.e_addr = e_addr; v.e_valid = e_valid; v.e_iaddr = e_iaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc     = '0;
        m_infl   = 1'b0;
        acc_prev = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " mem_req"},    32'(bus.mem_req),    32'(0));
        chk({tag, " mem_addr"},   32'(bus.mem_addr),   32'(0));
        chk({tag, " inst_valid"}, 32'(bus.inst_valid), 32'(0));
        chk({tag, " inst_o"},     32'(bus.inst_o),     32'(0));
        chk({tag, " inst_addr"},  32'(bus.inst_addr),  32'(0));
        chk({tag, " next_addr"},  32'(bus.next_addr),  32'(1));
    endtask

    // Release reset with idle inputs so no request slips through unmodelled
    task automatic release_reset();
        @(negedge clk);
        bus.ifetch_en  = 1'b0;
        bus.branch     = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.inst_ready = 1'b0;
        reset_         = 1'b1;
        model_reset();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.ifetch_en = 1'b1;
        bus.mem_gnt   = 1'b1;
        reset_        = 1'b0;
        #1;
        chk_reset("reset");
        release_reset();
    endtask

    // One clock: drive inputs on the falling edge, check just after, then
    // advance the model as of the next rising edge.
    task automatic cycle(input bit en, input bit br, input logic [AW-1:0] tgt,
                         input bit gnt, input bit rdy);
        bit            exp_valid;
        bit            pop;
        bit            exp_req;
        logic [AW-1:0] na;
        @(negedge clk);
        bus.ifetch_en  = en;
        bus.branch     = br;
        bus.tgt_addr   = tgt;
        bus.mem_gnt    = gnt;
        bus.inst_ready = rdy;
        bus.mem_rdata  = acc_prev ? memf(acc_addr) : 8'hEE;
        #1;
        exp_valid = (sb.size() - int'(m_infl)) != 0;
        pop       = exp_valid && rdy;
        exp_req   = en && !br && ((sb.size() - int'(pop)) < DEPTH);
        chk("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            na = sb[0].addr + 12'd1;
            chk("inst_addr", 32'(bus.inst_addr), 32'(sb[0].addr));
            chk("inst_o",    32'(bus.inst_o),    32'(sb[0].data));
            chk("next_addr", 32'(bus.next_addr), 32'(na));
        end
        chk("mem_req", 32'(bus.mem_req), 32'(exp_req));
        if (exp_req) chk("mem_addr", 32'(bus.mem_addr), 32'(m_pc));
        acc_prev = bus.mem_req && gnt;
        acc_addr = bus.mem_addr;
        if (pop) void'(sb.pop_front());
        if (br) begin
            sb.delete();
            m_infl = 1'b0;
            m_pc   = tgt;
        end else begin
            m_infl = 1'b0;
            if (exp_req && gnt) begin
                sb.push_back('{m_pc, memf(m_pc)});
                m_pc   = m_pc + 12'd1;
                m_infl = 1'b1;
            end
        end
    endtask

    initial begin
        int  n_acc;
        bit  seen;
        reset_         = 1'b0;
        bus.ifetch_en  = 1'b0;
        bus.branch     = 1'b0;
        bus.tgt_addr   = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rdata  = '0;
        bus.inst_ready = 1'b0;
        model_reset();

        // Streaming from reset: hand-derived expectations
        tbl[0] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000);
        tbl[1] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 12'h001, 1'b0, 12'h000);
        tbl[2] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 12'h002, 1'b1, 12'h000);
        tbl[3] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 12'h003, 1'b1, 12'h001);
        tbl[4] = mkv(1'b1, 1'b1, 1'b1, 1'b1, 12'h004, 1'b1, 12'h002);
        tbl[5] = mkv(1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 12'h003);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].en, 1'b0, 12'h000, tbl[i].gnt, tbl[i].rdy);
            chk("tbl mem_req",    32'(bus.mem_req),    32'(tbl[i].e_req));
            if (tbl[i].e_req)
                chk("tbl mem_addr", 32'(bus.mem_addr), 32'(tbl[i].e_addr));
            chk("tbl inst_valid", 32'(bus.inst_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk("tbl inst_addr", 32'(bus.inst_addr), 32'(tbl[i].e_iaddr));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

        // Consumer stalled: queue fills to DEPTH, then requests stop
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
            if (bus.mem_req && bus.mem_gnt) n_acc++;
        end
        chk("full accepts", 32'(n_acc), 32'(DEPTH));
        chk("full mem_req", 32'(bus.mem_req), 32'(0));
        chk("full head",    32'(bus.inst_addr), 32'(0));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

        // Branch with three entries queued and one response in flight
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 12'h100, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        chk("br inst_valid", 32'(bus.inst_valid), 32'(0));
        chk("br mem_req",    32'(bus.mem_req),    32'(1));
        chk("br mem_addr",   32'(bus.mem_addr),   32'(12'h100));
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        chk("br first inst", 32'(bus.inst_addr),  32'(12'h100));
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);

        // Address wrap across 0xFFF
        cycle(1'b1, 1'b1, 12'hFFD, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
            if (bus.inst_valid && bus.inst_addr == 12'hFFF) begin
                chk("wrap next_addr", 32'(bus.next_addr), 32'(0));
                seen = 1'b1;
            end
        end
        chk("wrap head seen", 32'(seen), 32'(1));

        // Random grant and ready, fetch disabled for five cycles
        for (int i = 0; i < 80; i++) begin
            cycle((i < 30 || i >= 35), 1'b0, 12'h000,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

        // Reset pulsed in the middle of a stream
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        chk_reset("midreset");
        release_reset();
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        chk("post-reset mem_addr", 32'(bus.mem_addr), 32'(0));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
